button_event_classifier: RTL
============================

Name: button_event_classifier

Overview:
- Sits directly downstream of the switch debouncer and consumes its debounced level output.
- Converts the clean level into single-cycle event pulses: press, release, short press and long press, plus a held-level flag.
- Outputs feed the control logic, e.g. mode select and manual reset requests, which need event semantics rather than levels.
- Single clock domain; the input is already synchronous to i_Clk.

Parameters:
- LONG_LIMIT, 12500000, cycles held before a press counts as long (0.5 s at 25 MHz); legal values are 2 or more.
- REPEAT_PERIOD, 2500000, cycles between auto-repeat pulses while long-held; used only with the optional feature.
- CNT_W, 24, counter width; must hold max(LONG_LIMIT, REPEAT_PERIOD).

Ports:
- i_Clk  input  1  system clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Switch  input  1  debounced switch level; 1 = pressed.
- o_Press  output  1  one-cycle pulse on press.
- o_Release  output  1  one-cycle pulse on release.
- o_Short  output  1  one-cycle pulse on release of a press shorter than LONG_LIMIT.
- o_Long  output  1  one-cycle pulse when a press reaches LONG_LIMIT.
- o_Repeat  output  1  auto-repeat pulse (optional feature).
- o_Held  output  1  level; 1 while state is not IDLE.

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - State = IDLE, counter = 0, previous-sample register r_Prev = 0.
  - All outputs are 0.
- All outputs are registered.
- Edge detection:
  - rise = i_Switch & ~r_Prev.
  - fall = ~i_Switch & r_Prev.
  - r_Prev <= i_Switch on every clock edge.
- Let E0 be the clock edge at which rise is detected.
- States:
  - IDLE:
    - On rise: go to HELD, counter <= 1, o_Press = 1 for the cycle after E0.
    - Otherwise no change.
  - HELD:
    - Counter increments each edge.
    - If fall: go to IDLE, and o_Release and o_Short both pulse in the same cycle.
    - Else if counter == LONG_LIMIT: go to LONG, counter <= 1, o_Long pulses. o_Long is therefore high exactly LONG_LIMIT cycles after o_Press.
  - LONG:
    - On fall: go to IDLE, o_Release pulses, o_Short stays 0.
    - The counter acts as the repeat counter (see Optional Feature).
- Boundary conditions:
  - Fall and long threshold on the same edge: fall wins, giving o_Short with no o_Long.
  - Press held for exactly LONG_LIMIT sampled-high edges (E0..E0+LONG_LIMIT-1) classifies as short. High at E0+LONG_LIMIT classifies as long.
  - Each press produces exactly one of o_Short or o_Long, never both and never neither.
  - At most one of o_Press, o_Release, o_Long, o_Repeat is high in any cycle. o_Short is only ever high together with o_Release.
  - Counter never wraps; width is guaranteed by CNT_W.
  - Switch high when reset releases: r_Prev = 0, so the first edge after release detects a press. This is intended.
  - Reset mid-press: outputs clear immediately and no o_Release or o_Short is emitted.
  - Single-cycle glitch (high for one edge): o_Press, then o_Release + o_Short on the next cycle. Filtering glitches is the debouncer's responsibility.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined:
  - In LONG, when counter == REPEAT_PERIOD, pulse o_Repeat and reset counter <= 1.
  - The first o_Repeat comes REPEAT_PERIOD cycles after o_Long, then every REPEAT_PERIOD cycles.
  - A fall on the same edge as a repeat suppresses the repeat and emits o_Release only.
- Not defined:
  - o_Repeat is tied to 0.
  - The counter holds its value in LONG.
  - No repeat logic is synthesised.

Test Plan (LONG_LIMIT=8, REPEAT_PERIOD=4, CNT_W=4):
- Reset held 5 cycles with i_Switch=1 -> all outputs 0. After release, o_Press is 1 for exactly one cycle.
- Rise at E0, low at E0+3 -> o_Press after E0, o_Release and o_Short after E0+3, o_Long never set, o_Held high for 3 cycles.
- High E0..E0+7, low at E0+8 -> o_Short after E0+8 and no o_Long. Repeat with high through E0+8 and low at E0+9 -> o_Long after E0+8, o_Release alone after E0+9.
- BTN_AUTO_REPEAT_EN defined, high E0..E0+18, low at E0+19:
  - o_Long after E0+8.
  - o_Repeat after E0+12 and E0+16.
  - o_Release after E0+19.
  - Undefined: same stimulus gives zero o_Repeat pulses.
- Reset asserted mid-cycle at E0+10 while in LONG -> o_Held drops immediately and no o_Release. After reset release with the switch still high, a new o_Press fires.
- Random presses of length 1–30 cycles against a scoreboard -> exactly one of o_Short or o_Long per press, one-hot pulse rule never violated, and o_Press count equals o_Release count.

Source files
------------

// File: rtl/button_event_classifier_if.sv
// Switch level in, classified button events out.
// slave = classifier side, master = driver/consumer side.
interface button_event_classifier_if;
  logic i_Switch;
  logic o_Press;
  logic o_Release;
  logic o_Short;
  logic o_Long;
  logic o_Repeat;
  logic o_Held;

  modport slave (
    input  i_Switch,
    output o_Press,
    output o_Release,
    output o_Short,
    output o_Long,
    output o_Repeat,
    output o_Held
  );

  modport master (
    output i_Switch,
    input  o_Press,
    input  o_Release,
    input  o_Short,
    input  o_Long,
    input  o_Repeat,
    input  o_Held
  );
endinterface

// File: rtl/button_event_classifier.sv
// Debounced level -> press/release/short/long pulses and held flag.
// Optional auto-repeat while long-held: define BTN_AUTO_REPEAT_EN.
module button_event_classifier #(
  parameter int LONG_LIMIT    = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_W         = 24
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  button_event_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (LONG_LIMIT < 2 || REPEAT_PERIOD < 1 ||
      LONG_LIMIT >= (1 << CNT_W) ||
      REPEAT_PERIOD >= (1 << CNT_W)) begin : g_bad_cfg
    $error("button_event_classifier: bad parameters");
  end

  state_t           r_State;
  logic [CNT_W-1:0] r_Cnt;
  logic             r_Prev;
  logic             r_Press;
  logic             r_Release;
  logic             r_Short;
  logic             r_Long;
  logic             r_Held;
  logic             w_Rise;
  logic             w_Fall;

  assign w_Rise = bus.i_Switch & ~r_Prev;
  assign w_Fall = ~bus.i_Switch & r_Prev;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_PERIOD);
  logic r_Repeat;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State   <= IDLE;
      r_Cnt     <= '0;
      r_Prev    <= 1'b0;
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
      r_Short   <= 1'b0;
      r_Long    <= 1'b0;
      r_Held    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_Repeat  <= 1'b0;
`endif
    end else begin
      r_Prev    <= bus.i_Switch;
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
      r_Short   <= 1'b0;
      r_Long    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_Repeat  <= 1'b0;
`endif
      unique case (r_State)
        IDLE: begin
          if (w_Rise) begin
            r_State <= HELD;
            r_Cnt   <= CNT_ONE;
            r_Press <= 1'b1;
            r_Held  <= 1'b1;
          end
        end
        HELD: begin
          // Fall is tested first so it wins over the long threshold.
          if (w_Fall) begin
            r_State   <= IDLE;
            r_Cnt     <= '0;
            r_Release <= 1'b1;
            r_Short   <= 1'b1;
            r_Held    <= 1'b0;
          end else if (r_Cnt == LONG_LIM) begin
            r_State <= LONG;
            r_Cnt   <= CNT_ONE;
            r_Long  <= 1'b1;
          end else begin
            r_Cnt <= r_Cnt + CNT_ONE;
          end
        end
        LONG: begin
          if (w_Fall) begin
            r_State   <= IDLE;
            r_Cnt     <= '0;
            r_Release <= 1'b1;
            r_Held    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
          end else if (r_Cnt == REP_LIM) begin
            r_Cnt    <= CNT_ONE;
            r_Repeat <= 1'b1;
          end else begin
            r_Cnt <= r_Cnt + CNT_ONE;
`endif
          end
        end
        default: begin
          r_State <= IDLE;
          r_Cnt   <= '0;
          r_Held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Press   = r_Press;
  assign bus.o_Release = r_Release;
  assign bus.o_Short   = r_Short;
  assign bus.o_Long    = r_Long;
  assign bus.o_Held    = r_Held;
`ifdef BTN_AUTO_REPEAT_EN
  assign bus.o_Repeat  = r_Repeat;
`else
  assign bus.o_Repeat  = 1'b0;
`endif

endmodule
